// File: rtl/fp_norm_round.sv
// fp_norm_round: post-exponent stage of the FP mult/div datapath.
// Normalizes the raw mantissa one shift per cycle, rounds to nearest-even,
// and packs an IEEE-754 single with exception flags behind valid/ready.
module fp_norm_round #(
  parameter int EXP_W  = 10,
  parameter int MAN_W  = 48,
  parameter int FRAC_W = 23
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [EXP_W-1:0] e,
  input  logic [MAN_W-1:0] man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             unf,
  output logic             inexact,
  output logic             zero
);
  localparam int XW = EXP_W + 1;
  localparam int GB = MAN_W - 3 - FRAC_W;
  localparam logic signed [XW-1:0] EX_ONE   = XW'(1);
  localparam logic signed [XW-1:0] EX_FLUSH = XW'(-24);
  localparam logic signed [XW-1:0] EX_INF   = XW'(255);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
  state_t r_state, w_state_nxt;

  logic                 r_s;
  logic signed [XW-1:0] r_ex;
  logic [MAN_W-1:0]     r_m;
  logic                 r_sticky;
  logic [31:0]          r_result;
  logic                 r_ovf, r_unf, r_inexact, r_zero;

  logic                 w_zero_hit, w_flush, w_rshift, w_lshift;
  logic                 w_g, w_rs, w_incr, w_hid_r, w_inexact;
  logic [FRAC_W+1:0]    w_sum;
  logic signed [XW-1:0] w_ex_r;
  logic [31:0]          w_res;
  logic                 w_ovf, w_unf, w_zero;

  // NORM decisions; priority is resolved where they are consumed
  always_comb begin
    w_zero_hit = (r_m == '0);
    w_flush    = (r_ex < EX_FLUSH);
    w_rshift   = r_m[MAN_W-1] | (r_ex < EX_ONE);
    w_lshift   = ~r_m[MAN_W-2] & (r_ex > EX_ONE);
  end

  // Round-to-nearest-even and result packing from the normalized mantissa
  always_comb begin
    w_g       = r_m[GB];
    w_rs      = (|r_m[GB-1:0]) | r_sticky;
    w_incr    = w_g & (w_rs | r_m[GB+1]);
    w_sum     = {1'b0, r_m[MAN_W-2:GB+1]} + {{(FRAC_W+1){1'b0}}, w_incr};
    w_ex_r    = w_sum[FRAC_W+1] ? r_ex + EX_ONE : r_ex;
    // a carry into the hidden position also promotes a subnormal to exp field 1
    w_hid_r   = |w_sum[FRAC_W+1:FRAC_W];
    w_inexact = w_g | w_rs;
    w_res     = {r_s, w_ex_r[7:0], w_sum[FRAC_W-1:0]};
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (w_ex_r >= EX_INF) begin
      w_res = {r_s, 8'hFF, {FRAC_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (!w_hid_r) begin
      w_res[30:FRAC_W] = '0;
      w_unf            = w_inexact;
    end
    w_zero = ~w_ovf & (w_res[30:0] == '0);
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = NORM;
      end
      NORM: begin
        if (w_zero_hit || w_flush)       w_state_nxt = OUT;
        else if (!w_rshift && !w_lshift) w_state_nxt = ROUND;
      end
      ROUND: w_state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Operand capture, shift datapath and registered result/flags
  always_ff @(posedge clk) begin
    if (arst) begin
      r_s       <= 1'b0;
      r_ex      <= '0;
      r_m       <= '0;
      r_sticky  <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_inexact <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s      <= sign;
            r_ex     <= XW'($signed(e));
            r_m      <= man;
            r_sticky <= 1'b0;
          end
        end
        NORM: begin
          if (w_zero_hit) begin
            r_result  <= {r_s, 31'b0};
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inexact <= 1'b0;
          end else if (w_flush) begin
            r_result  <= {r_s, 31'b0};
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b1;
            r_inexact <= 1'b1;
          end else if (w_rshift) begin
            r_m      <= r_m >> 1;
            r_sticky <= r_sticky | r_m[0];
            r_ex     <= r_ex + EX_ONE;
          end else if (w_lshift) begin
            r_m  <= r_m << 1;
            r_ex <= r_ex - EX_ONE;
          end
        end
        ROUND: begin
          r_result  <= w_res;
          r_ovf     <= w_ovf;
          r_unf     <= w_unf;
          r_inexact <= w_ovf | w_inexact;
          r_zero    <= w_zero;
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign inexact = r_inexact;
  assign zero    = r_zero;

endmodule
